// File: rtl/mem_pkg.sv
// Purpose: shared encodings for the MEM stage (load-size codes, FSM states).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_pkg;

  // Load-size encoding carried on i_ReadMem from the EX/MEM latch
  localparam logic [1:0] RD_NONE = 2'b00;
  localparam logic [1:0] RD_WORD = 2'b01;
  localparam logic [1:0] RD_BYTE = 2'b10;
  localparam logic [1:0] RD_NIB  = 2'b11;

  // Transaction FSM: waiting for an op, or holding a request on the RAM port
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } memState_t;

endpackage

// File: rtl/mem_load_align.sv
// Purpose: picks the word, byte or nibble lane out of RAM read data and zero-extends it.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module mem_load_align
  import mem_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        op,
  input  logic [1:0]        quarter,
  output logic [DATA_W-1:0] aligned
);

  // Lane select: bytes use only quarter[0], nibbles use the full quarter index
  always_comb begin
    aligned = '0;
    case (op)
      RD_WORD: aligned = rdata;
      RD_BYTE: aligned[7:0] = quarter[0] ? rdata[15:8] : rdata[7:0];
      RD_NIB: begin
        case (quarter)
          2'd0:    aligned[3:0] = rdata[3:0];
          2'd1:    aligned[3:0] = rdata[7:4];
          2'd2:    aligned[3:0] = rdata[11:8];
          default: aligned[3:0] = rdata[15:12];
        endcase
      end
      default: aligned = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Purpose: MEM pipeline stage running one req/ack data-RAM transaction per load/store op.
// Latency: op seen in cycle 0, mem_req from cycle 1, load result registered the cycle after mem_ack.
// Backpressure: o_stall holds upstream while an op is being captured or awaits ack; timeout faults out.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] i_DataAddress,
  input  logic [1:0]        i_ReadMem,
  input  logic              i_WriteMem,
  input  logic [1:0]        i_quarter,
  input  logic [DATA_W-1:0] i_StoreData,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] o_LoadData,
  output logic              o_LoadValid,
  output logic              o_MemFault,
  output logic              o_stall
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  memState_t         state;
  logic [1:0]        opReg;
  logic [1:0]        quarterReg;
  logic [CNT_W-1:0]  waitCount;
  logic [DATA_W-1:0] alignedData;
  logic              opPresent;
  logic              illegalOp;

  assign opPresent = (i_ReadMem != RD_NONE) || i_WriteMem;
  assign illegalOp = (i_ReadMem != RD_NONE) && i_WriteMem;

  // Stall drops in the ack cycle so upstream advances on the completing edge
  assign o_stall = ((state == IDLE) && opPresent && !illegalOp) ||
                   ((state == BUSY) && !mem_ack);

  mem_load_align #(.DATA_W(DATA_W)) uAlign (
    .rdata   (mem_rdata),
    .op      (opReg),
    .quarter (quarterReg),
    .aligned (alignedData)
  );

  // Transaction FSM: capture op, hold request until ack or timeout, register the result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      o_LoadData  <= '0;
      o_LoadValid <= 1'b0;
      o_MemFault  <= 1'b0;
      opReg       <= RD_NONE;
      quarterReg  <= 2'd0;
      waitCount   <= '0;
    end else begin
      o_LoadValid <= 1'b0;
      o_MemFault  <= 1'b0;
      case (state)
        IDLE: begin
          if (illegalOp) begin
            o_MemFault <= 1'b1;
          end else if (opPresent) begin
            mem_addr   <= i_DataAddress;
            mem_wdata  <= i_StoreData;
            opReg      <= i_ReadMem;
            quarterReg <= i_quarter;
            mem_req    <= 1'b1;
            mem_we     <= i_WriteMem;
            waitCount  <= '0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= IDLE;
            if (opReg != RD_NONE) begin
              o_LoadData  <= alignedData;
              o_LoadValid <= 1'b1;
            end
          end else if (waitCount == CNT_LAST) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            o_MemFault <= 1'b1;
            o_LoadData <= '0;
            state      <= IDLE;
          end else begin
            waitCount <= waitCount + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] i_DataAddress;
  logic [1:0]  i_ReadMem;
  logic        i_WriteMem;
  logic [1:0]  i_quarter;
  logic [15:0] i_StoreData;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic [15:0] o_LoadData;
  logic        o_LoadValid;
  logic        o_MemFault;
  logic        o_stall;

  int total = 0;
  int bad   = 0;
  // Model of the value o_LoadData should be holding
  logic [15:0] refLoad = 16'h0000;

  always #5 clk = ~clk;

  mem_access_stage #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(15)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_DataAddress (i_DataAddress),
    .i_ReadMem     (i_ReadMem),
    .i_WriteMem    (i_WriteMem),
    .i_quarter     (i_quarter),
    .i_StoreData   (i_StoreData),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_ack       (mem_ack),
    .o_LoadData    (o_LoadData),
    .o_LoadValid   (o_LoadValid),
    .o_MemFault    (o_MemFault),
    .o_stall       (o_stall)
  );

  // Reference lane extraction by shifting and masking
  function automatic logic [15:0] ref_align(input logic [1:0] rd, input logic [1:0] q,
                                            input logic [15:0] d);
    case (rd)
      2'b01:   return d;
      2'b10:   return (d >> (8 * q[0])) & 16'h00FF;
      2'b11:   return (d >> (4 * q)) & 16'h000F;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_ReadMem = 2'b00; i_WriteMem = 1'b0; i_quarter = 2'd0;
    i_DataAddress = 16'h0; i_StoreData = 16'h0;
  endtask

  // One complete legal transaction; leaves the stage IDLE one edge after the ack edge
  task automatic do_op(input logic [1:0] rd, input logic wr, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic [1:0] q,
                       input logic [15:0] rdata, input int waits, input string tag);
    logic [15:0] expLoad;
    i_ReadMem = rd; i_WriteMem = wr; i_DataAddress = addr; i_StoreData = wdata; i_quarter = q;
    mem_ack = 1'b0; mem_rdata = 16'(($urandom));
    #1;
    total++;
    if (o_stall !== 1'b1) begin bad++; $display("FAIL %s stall_capture: got %b want 1", tag, o_stall); end
    tick();
    total++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, wr, addr}) begin
      bad++; $display("FAIL %s req_issue: got req=%b we=%b addr=%h want req=1 we=%b addr=%h",
                      tag, mem_req, mem_we, mem_addr, wr, addr);
    end
    if (wr) begin
      total++;
      if (mem_wdata !== wdata) begin bad++; $display("FAIL %s wdata: got %h want %h", tag, mem_wdata, wdata); end
    end
    total++;
    if ({o_LoadValid, o_MemFault} !== 2'b00) begin
      bad++; $display("FAIL %s pulse_width: got valid=%b fault=%b want 0 0", tag, o_LoadValid, o_MemFault);
    end
    for (int i = 0; i < waits; i++) begin
      mem_rdata = 16'($urandom);
      #1;
      total++;
      if (o_stall !== 1'b1) begin bad++; $display("FAIL %s stall_wait%0d: got %b want 1", tag, i, o_stall); end
      tick();
      total++;
      if ({mem_req, mem_we, mem_addr} !== {1'b1, wr, addr}) begin
        bad++; $display("FAIL %s req_hold%0d: got req=%b we=%b addr=%h want req=1 we=%b addr=%h",
                        tag, i, mem_req, mem_we, mem_addr, wr, addr);
      end
    end
    mem_ack = 1'b1; mem_rdata = rdata;
    #1;
    total++;
    if (o_stall !== 1'b0) begin bad++; $display("FAIL %s stall_ack: got %b want 0", tag, o_stall); end
    tick();
    mem_ack = 1'b0;
    clear_inputs();
    if (rd != 2'b00) refLoad = ref_align(rd, q, rdata);
    expLoad = refLoad;
    total++;
    if ({mem_req, o_LoadValid, o_MemFault} !== {1'b0, (rd != 2'b00), 1'b0}) begin
      bad++; $display("FAIL %s complete: got req=%b valid=%b fault=%b want req=0 valid=%b fault=0",
                      tag, mem_req, o_LoadValid, o_MemFault, (rd != 2'b00));
    end
    total++;
    if (o_LoadData !== expLoad) begin bad++; $display("FAIL %s load_data: got %h want %h", tag, o_LoadData, expLoad); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = 16'h0; clear_inputs();
    tick(); tick();
    total++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, o_LoadData, o_LoadValid, o_MemFault, o_stall} !== 53'd0) begin
      bad++; $display("FAIL reset_state: got req=%b we=%b addr=%h wdata=%h load=%h valid=%b fault=%b stall=%b want all 0",
                      mem_req, mem_we, mem_addr, mem_wdata, o_LoadData, o_LoadValid, o_MemFault, o_stall);
    end
    rst_n = 1'b1;
    refLoad = 16'h0;
    tick();
  endtask

  task automatic test_directed();
    do_op(2'b01, 1'b0, 16'h0040, 16'h0000, 2'd0, 16'hBEEF, 0, "word_read");
    do_op(2'b10, 1'b0, 16'h0041, 16'h0000, 2'd1, 16'hA55A, 0, "byte_q1");
    do_op(2'b10, 1'b0, 16'h0042, 16'h0000, 2'd0, 16'hA55A, 1, "byte_q0");
    do_op(2'b11, 1'b0, 16'h0043, 16'h0000, 2'd3, 16'h1234, 0, "nib_q3");
    do_op(2'b11, 1'b0, 16'h0044, 16'h0000, 2'd0, 16'h1234, 2, "nib_q0");
    do_op(2'b00, 1'b1, 16'h0010, 16'h00FF, 2'd2, 16'h5555, 3, "write");
  endtask

  task automatic test_back_to_back();
    logic [1:0] rd;
    for (int n = 0; n < 40; n++) begin
      rd = 2'($urandom_range(0, 3));
      do_op(rd, (rd == 2'b00), 16'($urandom), 16'($urandom), 2'($urandom),
            16'($urandom), int'($urandom_range(0, 4)), "random");
      if ($urandom_range(0, 3) == 0) begin
        #1;
        total++;
        if (o_stall !== 1'b0) begin bad++; $display("FAIL gap_stall: got %b want 0", o_stall); end
        tick();
        total++;
        if ({mem_req, o_LoadValid} !== 2'b00) begin
          bad++; $display("FAIL gap_idle: got req=%b valid=%b want 0 0", mem_req, o_LoadValid);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int reqCycles;
    i_ReadMem = 2'b01; i_WriteMem = 1'b0; i_DataAddress = 16'h7777; mem_ack = 1'b0;
    tick();
    reqCycles = 0;
    for (int c = 0; c < 40 && mem_req === 1'b1; c++) begin
      reqCycles++;
      mem_rdata = 16'($urandom);
      tick();
    end
    clear_inputs();
    refLoad = 16'h0;
    total++;
    if (reqCycles != 15) begin bad++; $display("FAIL timeout_len: got %0d busy cycles want 15", reqCycles); end
    total++;
    if ({mem_req, o_MemFault, o_LoadValid} !== 3'b010) begin
      bad++; $display("FAIL timeout_fault: got req=%b fault=%b valid=%b want 0 1 0", mem_req, o_MemFault, o_LoadValid);
    end
    total++;
    if (o_LoadData !== refLoad) begin bad++; $display("FAIL timeout_load: got %h want %h", o_LoadData, refLoad); end
    #1;
    total++;
    if (o_stall !== 1'b0) begin bad++; $display("FAIL timeout_stall: got %b want 0", o_stall); end
    tick();
    total++;
    if (o_MemFault !== 1'b0) begin bad++; $display("FAIL timeout_pulse: got %b want 0", o_MemFault); end
  endtask

  task automatic test_illegal();
    for (int n = 0; n < 3; n++) begin
      i_ReadMem = 2'($urandom_range(1, 3)); i_WriteMem = 1'b1; i_DataAddress = 16'($urandom);
      #1;
      total++;
      if (o_stall !== 1'b0) begin bad++; $display("FAIL illegal_stall: got %b want 0", o_stall); end
      tick();
      clear_inputs();
      total++;
      if ({mem_req, o_MemFault, o_LoadValid} !== 3'b010) begin
        bad++; $display("FAIL illegal_fault: got req=%b fault=%b valid=%b want 0 1 0", mem_req, o_MemFault, o_LoadValid);
      end
      tick();
      total++;
      if ({mem_req, o_MemFault} !== 2'b00) begin
        bad++; $display("FAIL illegal_pulse: got req=%b fault=%b want 0 0", mem_req, o_MemFault);
      end
    end
  endtask

  task automatic test_reset_mid_busy();
    i_ReadMem = 2'b01; i_WriteMem = 1'b0; i_DataAddress = 16'h1357; i_StoreData = 16'h2468;
    mem_ack = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    rst_n = 1'b1;
    refLoad = 16'h0;
    total++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, o_LoadData, o_LoadValid, o_MemFault} !== 52'd0) begin
      bad++; $display("FAIL reset_mid: got req=%b we=%b addr=%h wdata=%h load=%h valid=%b fault=%b want all 0",
                      mem_req, mem_we, mem_addr, mem_wdata, o_LoadData, o_LoadValid, o_MemFault);
    end
    mem_ack = 1'b1; mem_rdata = 16'hCAFE;
    tick();
    mem_ack = 1'b0;
    tick();
    total++;
    if ({mem_req, o_LoadValid, o_LoadData} !== 18'd0) begin
      bad++; $display("FAIL late_ack: got req=%b valid=%b load=%h want 0 0 0000", mem_req, o_LoadValid, o_LoadData);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_timeout();
    test_illegal();
    test_reset_mid_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
